// File: rtl/counter_sequencer.sv
// counter_sequencer: start/stop/pause counter that runs 0..limit and pulses done at terminal count.
// Define COUNTER_SEQUENCER_AUTO_RELOAD_EN to make the count wrap to 0 periodically instead of stopping.
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] q_n, limit_r, limit_n;
  logic done_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      q       <= '0;
      limit_r <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      q       <= q_n;
      limit_r <= limit_n;
      done    <= done_n;
    end
  end
  // priority: stop > start > pause > count
  always_comb begin
    state_n = state;
    q_n     = q;
    limit_n = limit_r;
    done_n  = 1'b0;
    if (stop) begin
      state_n = IDLE;
      q_n     = '0;
    end else if (start && (state == IDLE || state == DONE)) begin
      state_n = RUN;
      q_n     = '0;
      limit_n = limit;
    end else if (state == RUN && pause) begin
      state_n = HOLD;
    end else if (state == HOLD) begin
      state_n = pause ? HOLD : RUN;
    end else if (state == RUN) begin
      if (q != limit_r) begin
        q_n = q + WIDTH'(1);
      end else begin
        done_n = 1'b1;
`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
        q_n = '0;
`else
        state_n = DONE;
`endif
      end
    end
  end
  assign busy = (state == RUN) || (state == HOLD);
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed vector table plus hand-written async-reset and max-limit sequences.
module tb_counter_sequencer;
  typedef struct {
    logic       st, sp, pa;
    logic [3:0] lim;
    logic [3:0] q;
    logic       b, d;
  } vec_t;

`ifdef COUNTER_SEQUENCER_AUTO_RELOAD_EN
  localparam bit RL = 1'b1;
`else
  localparam bit RL = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [3:0] limit = '0, q;
  logic busy, done;
  int errors = 0, checks = 0;
  vec_t vs[$];

  counter_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .limit(limit), .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int eq, input int eb, input int ed);
    chk({tag, "_q"}, int'(q), eq);
    chk({tag, "_busy"}, int'(busy), eb);
    chk({tag, "_done"}, int'(done), ed);
  endtask

  task automatic add(input logic st, sp, pa, input logic [3:0] lim, q_e, input logic b, d);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = pa; v.lim = lim; v.q = q_e; v.b = b; v.d = d;
    vs.push_back(v);
  endtask

  task automatic step(input logic st, sp, pa, input logic [3:0] lim);
    start = st; stop = sp; pause = pa; limit = lim;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk_out("reset", 0, 0, 0);
    #4 reset = 1'b1;
    #1;
    chk_out("reset_rel", 0, 0, 0);

    if (!RL) begin
      // single-shot run to 5, then hold in DONE
      add(1,0,0,5, 0,1,0);
      add(0,0,0,5, 1,1,0); add(0,0,0,5, 2,1,0); add(0,0,0,5, 3,1,0);
      add(0,0,0,5, 4,1,0); add(0,0,0,5, 5,1,0);
      add(0,0,0,5, 5,0,1); add(0,0,0,5, 5,0,0); add(0,0,0,2, 5,0,0);
      // limit change and start during RUN are ignored
      add(1,0,0,5, 0,1,0); add(0,0,0,2, 1,1,0); add(1,0,0,2, 2,1,0);
      add(0,0,0,2, 3,1,0); add(0,0,0,2, 4,1,0); add(0,0,0,2, 5,1,0);
      add(0,0,0,2, 5,0,1);
      // pause at q=3 for three edges, then resume
      add(1,0,0,7, 0,1,0); add(0,0,0,7, 1,1,0); add(0,0,0,7, 2,1,0); add(0,0,0,7, 3,1,0);
      add(0,0,1,7, 3,1,0); add(0,0,1,7, 3,1,0); add(0,0,1,7, 3,1,0);
      add(0,0,0,7, 3,1,0); add(0,0,0,7, 4,1,0); add(0,0,0,7, 5,1,0);
      add(0,0,0,7, 6,1,0); add(0,0,0,7, 7,1,0); add(0,0,0,7, 7,0,1);
      // stop+pause at q=4, then limit=0 run
      add(1,0,0,7, 0,1,0); add(0,0,0,7, 1,1,0); add(0,0,0,7, 2,1,0);
      add(0,0,0,7, 3,1,0); add(0,0,0,7, 4,1,0);
      add(0,1,1,7, 0,0,0); add(0,0,0,7, 0,0,0);
      add(1,0,0,0, 0,1,0); add(0,0,0,9, 0,0,1); add(0,0,0,9, 0,0,0);
      // stop beats start
      add(1,1,0,3, 0,0,0); add(1,0,0,3, 0,1,0); add(1,1,1,3, 0,0,0);
      foreach (vs[i]) begin
        step(vs[i].st, vs[i].sp, vs[i].pa, vs[i].lim);
        chk_out($sformatf("v%0d", i), vs[i].q, vs[i].b, vs[i].d);
      end
    end else begin
      step(1,0,0,3);
      chk_out("rl_start", 0, 1, 0);
      for (int k = 1; k <= 9; k++) begin
        step(0,0,0,3);
        chk_out($sformatf("rl%0d", k), k % 4, 1, (k % 4 == 0) ? 1 : 0);
      end
      step(0,1,0,3);
      chk_out("rl_stop", 0, 0, 0);
    end

    // async reset between edges at q=2
    step(1,0,0,5);
    step(0,0,0,5);
    step(0,0,0,5);
    chk_out("ar_pre", 2, 1, 0);
    #2 reset = 1'b0;
    #1;
    chk_out("ar_now", 0, 0, 0);
    @(posedge clk);
    #1;
    chk_out("ar_held", 0, 0, 0);
    #2 reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(0,0,0,5);
      chk_out($sformatf("ar_post%0d", k), 0, 0, 0);
    end

    // maximum limit: no wrap past 15
    step(1,0,0,15);
    chk_out("max_start", 0, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      step(0,0,0,15);
      chk_out($sformatf("max%0d", k), k, 1, 0);
    end
    step(0,0,0,15);
    chk_out("max_term", RL ? 0 : 15, RL ? 1 : 0, 1);
    step(0,1,0,15);
    chk_out("max_stop", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
